pe_packet_decoder: RTL and testbench

// Clocked receive end of the PE input packet stream (filter rows, spike ifmap windows). Decodes each

---
 rtl/pe_packet_decoder.sv | 189 ++++++++++++++++++
 tb/tb_pe_packet_decoder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_packet_decoder.sv
// Receive-side packet decoder for a PE: assembles the 3x3 filter and pairs each ifmap window with it.
// Optional timestep-order checking is enabled by defining PE_DEC_TS_CHECK_EN.
module pe_packet_decoder #(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned PACKET_WIDTH = 5 * FILTER_WIDTH + 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PACKET_WIDTH-1:0]   in_data,
  input  logic                      flush,
  output logic                      cmd_valid,
  input  logic                      cmd_ready,
  output logic [9*FILTER_WIDTH-1:0] cmd_filter,
  output logic [8:0]                cmd_ifmap,
  output logic                      cmd_ts,
  output logic                      filter_loaded,
  output logic [2:0]                err_flags
);

  localparam int unsigned CMD_W   = 9 * FILTER_WIDTH;
  localparam int unsigned W2_LSB  = 5;
  localparam int unsigned W1_LSB  = W2_LSB + FILTER_WIDTH;
  localparam int unsigned W0_LSB  = W1_LSB + FILTER_WIDTH;
  localparam int unsigned IFM_LSB = 22;
  localparam int unsigned IFM_W   = 9;
  localparam int unsigned IFM_MSB = IFM_LSB + IFM_W - 1;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_READY   = 2'd1,
    ST_ISSUE   = 2'd2
  } state_e;

  state_e                                state_q, state_d;
  logic [2:0]                            fmask_q, fmask_d;
  logic [8:0][FILTER_WIDTH-1:0]          filt_q, filt_d;
  logic [1:0]                            err_q, err_d;
  logic                                  cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0]                      cmd_filter_q, cmd_filter_d;
  logic [IFM_W-1:0]                      cmd_ifmap_q, cmd_ifmap_d;
  logic                                  cmd_ts_q, cmd_ts_d;
  logic                                  loaded_q;

  logic                    accept_c;
  logic                    is_filter_c;
  logic                    issue_c;
  logic                    pkt_ts_c;
  logic [2:0]              row_idx_c;
  logic [FILTER_WIDTH-1:0] w0_c, w1_c, w2_c;
  logic [IFM_W-1:0]        ifmap_c;
  logic                    unused_hi_c;

  // Packet field decode
  assign pkt_ts_c    = in_data[0];
  assign is_filter_c = in_data[1];
  assign row_idx_c   = in_data[4:2];
  assign w0_c        = in_data[W0_LSB +: FILTER_WIDTH];
  assign w1_c        = in_data[W1_LSB +: FILTER_WIDTH];
  assign w2_c        = in_data[W2_LSB +: FILTER_WIDTH];
  assign ifmap_c     = in_data[IFM_MSB:IFM_LSB];
  assign unused_hi_c = ^in_data[PACKET_WIDTH-1:IFM_MSB+1];

  // Ready depends only on flush and registered state, never on the incoming packet
  assign in_ready = !flush && (state_q != ST_ISSUE);
  assign accept_c = in_valid && in_ready;
  assign issue_c  = accept_c && !is_filter_c && (state_q == ST_READY);

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    fmask_d      = fmask_q;
    filt_d       = filt_q;
    err_d        = err_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_filter_d = cmd_filter_q;
    cmd_ifmap_d  = cmd_ifmap_q;
    cmd_ts_d     = cmd_ts_q;

    if (flush) begin
      state_d     = ST_COLLECT;
      fmask_d     = 3'b000;
      err_d       = 2'b00;
      cmd_valid_d = 1'b0;
    end else if (state_q == ST_ISSUE) begin
      if (cmd_ready) begin
        state_d     = ST_READY;
        cmd_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      if (is_filter_c) begin
        // f0 sits in the top slice, so row r lands at indices 8-3(r-1) .. 6-3(r-1)
        unique case (row_idx_c)
          3'd1: begin
            filt_d[8]  = w0_c;
            filt_d[7]  = w1_c;
            filt_d[6]  = w2_c;
            fmask_d[0] = 1'b1;
          end
          3'd2: begin
            filt_d[5]  = w0_c;
            filt_d[4]  = w1_c;
            filt_d[3]  = w2_c;
            fmask_d[1] = 1'b1;
          end
          3'd3: begin
            filt_d[2]  = w0_c;
            filt_d[1]  = w1_c;
            filt_d[0]  = w2_c;
            fmask_d[2] = 1'b1;
          end
          default: err_d[0] = 1'b1;
        endcase
        if (&fmask_d) begin
          state_d = ST_READY;
        end
      end else if (state_q == ST_READY) begin
        state_d      = ST_ISSUE;
        cmd_valid_d  = 1'b1;
        cmd_filter_d = filt_q;
        cmd_ifmap_d  = ifmap_c;
        cmd_ts_d     = pkt_ts_c;
      end else begin
        err_d[1] = 1'b1;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_COLLECT;
      fmask_q      <= 3'b000;
      filt_q       <= '0;
      err_q        <= 2'b00;
      cmd_valid_q  <= 1'b0;
      cmd_filter_q <= '0;
      cmd_ifmap_q  <= '0;
      cmd_ts_q     <= 1'b0;
      loaded_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fmask_q      <= fmask_d;
      filt_q       <= filt_d;
      err_q        <= err_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_filter_q <= cmd_filter_d;
      cmd_ifmap_q  <= cmd_ifmap_d;
      cmd_ts_q     <= cmd_ts_d;
      loaded_q     <= &fmask_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_filter    = cmd_filter_q;
  assign cmd_ifmap     = cmd_ifmap_q;
  assign cmd_ts        = cmd_ts_q;
  assign filter_loaded = loaded_q;

`ifdef PE_DEC_TS_CHECK_EN
  logic exp_ts_q;
  logic ts_err_q;

  // Expected timestep flips per issued command; a mismatch still issues but is flagged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_ts_q <= 1'b0;
      ts_err_q <= 1'b0;
    end else if (flush) begin
      exp_ts_q <= 1'b0;
      ts_err_q <= 1'b0;
    end else if (issue_c) begin
      exp_ts_q <= !exp_ts_q;
      if (pkt_ts_c != exp_ts_q) begin
        ts_err_q <= 1'b1;
      end
    end
  end

  assign err_flags = {ts_err_q, err_q};
`else
  logic unused_issue_c;

  assign unused_issue_c = issue_c;
  assign err_flags      = {1'b0, err_q};
`endif

endmodule

// File: tb/tb_pe_packet_decoder.sv
// Directed self-checking bench for pe_packet_decoder.
module tb_pe_packet_decoder;

  localparam int unsigned FW = 8;
  localparam int unsigned PW = 45;
  localparam int unsigned CW = 72;

`ifdef PE_DEC_TS_CHECK_EN
  localparam logic TS_ERR_EXP = 1'b1;
`else
  localparam logic TS_ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] in_data;
  logic          flush;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_filter;
  logic [8:0]    cmd_ifmap;
  logic          cmd_ts;
  logic          filter_loaded;
  logic [2:0]    err_flags;

  int n_cmp = 0;
  int n_bad = 0;

  pe_packet_decoder #(.FILTER_WIDTH(FW), .PACKET_WIDTH(PW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .flush         (flush),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_filter    (cmd_filter),
    .cmd_ifmap     (cmd_ifmap),
    .cmd_ts        (cmd_ts),
    .filter_loaded (filter_loaded),
    .err_flags     (err_flags)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] row_pkt(input logic ts, input logic [2:0] r,
                                             input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c);
    return {16'd0, a, b, c, r, 1'b1, ts};
  endfunction

  function automatic logic [PW-1:0] ifm_pkt(input logic ts, input logic [8:0] s);
    return {14'd0, s, 20'd0, 1'b0, ts};
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [PW-1:0] p);
    in_valid = 1'b1;
    in_data  = p;
    cycle();
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic handshake();
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
  endtask

  task automatic load_filter();
    send(45'h0A15FE6);
    send(row_pkt(1'b0, 3'd2, 8'h11, 8'h22, 8'h33));
    send(row_pkt(1'b0, 3'd3, 8'h44, 8'h55, 8'h66));
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; cmd_ready = 1'b0;
    #12;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_filter !== 72'd0) begin n_bad++; $display("FAIL rst_cmd_filter got %h want 0", cmd_filter); end
    n_cmp++; if (cmd_ifmap !== 9'd0) begin n_bad++; $display("FAIL rst_cmd_ifmap got %h want 0", cmd_ifmap); end
    n_cmp++; if (filter_loaded !== 1'b0) begin n_bad++; $display("FAIL rst_filter_loaded got %b want 0", filter_loaded); end
    n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL rst_err_flags got %b want 000", err_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_ifmap_before_filter();
    send(45'h7FC00020);
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL early_ifm_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (err_flags !== 3'b010) begin n_bad++; $display("FAIL early_ifm_err got %b want 010", err_flags); end
    do_flush();
    n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL early_ifm_flush_err got %b want 000", err_flags); end
  endtask

  task automatic test_filter_load();
    send(45'h0A15FE6);
    n_cmp++; if (filter_loaded !== 1'b0) begin n_bad++; $display("FAIL load_r1 got %b want 0", filter_loaded); end
    send(row_pkt(1'b0, 3'd2, 8'h11, 8'h22, 8'h33));
    n_cmp++; if (filter_loaded !== 1'b0) begin n_bad++; $display("FAIL load_r2 got %b want 0", filter_loaded); end
    send(row_pkt(1'b0, 3'd3, 8'h44, 8'h55, 8'h66));
    n_cmp++; if (filter_loaded !== 1'b1) begin n_bad++; $display("FAIL load_r3 got %b want 1", filter_loaded); end
    send(45'h7FC00020);
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("FAIL cmd1_valid got %b want 1", cmd_valid); end
    n_cmp++; if (cmd_ifmap !== 9'h1FF) begin n_bad++; $display("FAIL cmd1_ifmap got %h want 1ff", cmd_ifmap); end
    n_cmp++; if (cmd_ts !== 1'b0) begin n_bad++; $display("FAIL cmd1_ts got %b want 0", cmd_ts); end
    n_cmp++; if (cmd_filter[71:48] !== 24'h050AFF) begin n_bad++; $display("FAIL cmd1_row1 got %h want 050aff", cmd_filter[71:48]); end
    n_cmp++; if (cmd_filter !== 72'h050AFF_112233_445566) begin n_bad++; $display("FAIL cmd1_filter got %h want 050aff112233445566", cmd_filter); end
    handshake();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL cmd1_drop got %b want 0", cmd_valid); end
  endtask

  task automatic test_bad_row();
    send(row_pkt(1'b0, 3'b101, 8'hAA, 8'hBB, 8'hCC));
    n_cmp++; if (err_flags[1:0] !== 2'b01) begin n_bad++; $display("FAIL bad_row_err got %b want 01", err_flags[1:0]); end
    n_cmp++; if (filter_loaded !== 1'b1) begin n_bad++; $display("FAIL bad_row_loaded got %b want 1", filter_loaded); end
    send(ifm_pkt(1'b1, 9'h001));
    n_cmp++; if (cmd_filter !== 72'h050AFF_112233_445566) begin n_bad++; $display("FAIL bad_row_filter got %h want 050aff112233445566", cmd_filter); end
    handshake();
    send(row_pkt(1'b0, 3'd2, 8'h77, 8'h88, 8'h99));
    n_cmp++; if (filter_loaded !== 1'b1) begin n_bad++; $display("FAIL rewrite_loaded got %b want 1", filter_loaded); end
    send(ifm_pkt(1'b0, 9'h002));
    n_cmp++; if (cmd_filter !== 72'h050AFF_778899_445566) begin n_bad++; $display("FAIL rewrite_filter got %h want 050aff778899445566", cmd_filter); end
    handshake();
  endtask

  task automatic test_back_to_back();
    send(ifm_pkt(1'b1, 9'h0A5));
    in_valid = 1'b1;
    in_data  = ifm_pkt(1'b0, 9'h15A);
    for (int i = 0; i < 5; i++) begin
      cycle();
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready[%0d] got %b want 0", i, in_ready); end
      n_cmp++; if (cmd_valid !== 1'b1 || cmd_ifmap !== 9'h0A5) begin n_bad++; $display("FAIL stall_cmd[%0d] got %b/%h want 1/0a5", i, cmd_valid, cmd_ifmap); end
    end
    handshake();
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid got %b want 0", cmd_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_ready got %b want 1", in_ready); end
    cycle();
    in_valid = 1'b0;
    in_data  = '0;
    n_cmp++; if (cmd_valid !== 1'b1 || cmd_ifmap !== 9'h15A) begin n_bad++; $display("FAIL b2b_second got %b/%h want 1/15a", cmd_valid, cmd_ifmap); end
    handshake();
  endtask

  task automatic test_ts_check();
    do_flush();
    load_filter();
    send(ifm_pkt(1'b0, 9'h003));
    n_cmp++; if (cmd_ts !== 1'b0 || err_flags[2] !== 1'b0) begin n_bad++; $display("FAIL ts1 got ts=%b err2=%b want 0/0", cmd_ts, err_flags[2]); end
    handshake();
    send(ifm_pkt(1'b1, 9'h004));
    n_cmp++; if (cmd_ts !== 1'b1 || err_flags[2] !== 1'b0) begin n_bad++; $display("FAIL ts2 got ts=%b err2=%b want 1/0", cmd_ts, err_flags[2]); end
    handshake();
    send(ifm_pkt(1'b1, 9'h005));
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("FAIL ts3_valid got %b want 1", cmd_valid); end
    n_cmp++; if (err_flags[2] !== TS_ERR_EXP) begin n_bad++; $display("FAIL ts3_err2 got %b want %b", err_flags[2], TS_ERR_EXP); end
    handshake();
  endtask

  task automatic test_flush();
    send(ifm_pkt(1'b0, 9'h006));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = ifm_pkt(1'b1, 9'h007);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_in_ready got %b want 0", in_ready); end
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL flush_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (filter_loaded !== 1'b0) begin n_bad++; $display("FAIL flush_loaded got %b want 0", filter_loaded); end
    n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL flush_err got %b want 000", err_flags); end
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after_ready got %b want 1", in_ready); end
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = ifm_pkt(1'b0, 9'h008);
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_cmp++; if (err_flags !== 3'b000) begin n_bad++; $display("FAIL flush_wins_err got %b want 000", err_flags); end
  endtask

  task automatic test_async_reset();
    load_filter();
    send(row_pkt(1'b0, 3'd0, 8'h01, 8'h02, 8'h03));
    send(ifm_pkt(1'b0, 9'h0F0));
    n_cmp++; if (cmd_valid !== 1'b1) begin n_bad++; $display("FAIL arst_pre_valid got %b want 1", cmd_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (cmd_valid !== 1'b0) begin n_bad++; $display("FAIL arst_cmd_valid got %b want 0", cmd_valid); end
    n_cmp++; if (cmd_filter !== 72'd0 || cmd_ifmap !== 9'd0) begin n_bad++; $display("FAIL arst_cmd_data got %h/%h want 0/0", cmd_filter, cmd_ifmap); end
    n_cmp++; if (filter_loaded !== 1'b0 || err_flags !== 3'b000) begin n_bad++; $display("FAIL arst_status got %b/%b want 0/000", filter_loaded, err_flags); end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    n_cmp++; if (in_ready !== 1'b1 || cmd_valid !== 1'b0) begin n_bad++; $display("FAIL arst_release got %b/%b want 1/0", in_ready, cmd_valid); end
  endtask

  initial begin
    test_reset();
    test_ifmap_before_filter();
    test_filter_load();
    test_bad_row();
    test_back_to_back();
    test_ts_check();
    test_flush();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
